// File: rtl/inst_mem_ctrl.sv
// Instruction-memory sequencer: buffers a host program, issues it as one gap-free burst,
// waits for the delayed read-out, and replays the buffered program cfg_rep more times.
//
// state  | meaning
// IDLE   | waiting for start; cfg_len checked here
// FILL   | accepting host words into the buffer
// ISSUE  | driving imem_in_v for len consecutive cycles
// DRAIN  | counting read-out pulses under watchdog
// GAP    | two idle cycles so the memory's control delay line empties before a replay
// DONE   | one-cycle done pulse
module inst_mem_ctrl #(
    parameter int INST_WIDTH = 36,
    parameter int MAX_PROG   = 16,
    parameter int CNT_W      = 5,
    parameter int REP_W      = 8,
    parameter int IM_DELAY   = 20,
    parameter int WD_SLACK   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [CNT_W-1:0]      cfg_len,
    input  logic [REP_W-1:0]      cfg_rep,
    input  logic                  host_v,
    input  logic [INST_WIDTH-1:0] host_inst,
    output logic                  host_rdy,
    output logic                  imem_in_v,
    output logic [INST_WIDTH-1:0] imem_in,
    input  logic                  imem_out_v,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FILL  = 3'd1;
    localparam logic [2:0] S_ISSUE = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_GAP   = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    localparam int AW   = (MAX_PROG > 1) ? $clog2(MAX_PROG) : 1;
    localparam int WD_W = $clog2(IM_DELAY + MAX_PROG + WD_SLACK + 1);

    logic [2:0]            state;
    logic [CNT_W-1:0]      len;
    logic [CNT_W-1:0]      wptr;
    logic [CNT_W-1:0]      rptr;
    logic [CNT_W-1:0]      rd_cnt;
    logic [REP_W-1:0]      rep;
    logic [WD_W-1:0]       wd;
    logic                  gap_cnt;
    logic [INST_WIDTH-1:0] prog_buf [MAX_PROG];

    logic                  wr_fire;
    logic                  last_wr;
    logic                  last_rd;
    logic                  rd_inc;
    logic                  cfg_bad;
    logic [CNT_W-1:0]      rptr_inc;
    logic [CNT_W-1:0]      rd_cnt_nxt;
    logic [WD_W-1:0]       wd_last;

    assign wr_fire    = (state == S_FILL) && host_v && host_rdy;
    assign last_wr    = (wptr == len - 1'b1);
    assign last_rd    = (rptr == len - 1'b1);
    assign rptr_inc   = rptr + 1'b1;
    assign rd_inc     = imem_out_v && (rd_cnt < len);
    assign rd_cnt_nxt = rd_cnt + {{(CNT_W-1){1'b0}}, rd_inc};
    assign cfg_bad    = (cfg_len == '0) || (cfg_len > CNT_W'(MAX_PROG));
    // err is registered, so trip one cycle before the watchdog reaches its limit.
    assign wd_last    = WD_W'(IM_DELAY + WD_SLACK - 1) + WD_W'(len);

    always_ff @(posedge clk) begin
        if (wr_fire)
            prog_buf[wptr[AW-1:0]] <= host_inst;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            len       <= '0;
            wptr      <= '0;
            rptr      <= '0;
            rd_cnt    <= '0;
            rep       <= '0;
            wd        <= '0;
            gap_cnt   <= 1'b0;
            host_rdy  <= 1'b0;
            imem_in_v <= 1'b0;
            imem_in   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (cfg_bad) begin
                            err <= 1'b1;
                        end else begin
                            len      <= cfg_len;
                            rep      <= cfg_rep;
                            wptr     <= '0;
                            host_rdy <= 1'b1;
                            busy     <= 1'b1;
                            state    <= S_FILL;
                        end
                    end
                end
                S_FILL: begin
                    if (wr_fire) begin
                        wptr <= wptr + 1'b1;
                        if (last_wr) begin
                            host_rdy  <= 1'b0;
                            imem_in_v <= 1'b1;
                            // a one-word program is still in flight to the buffer
                            imem_in   <= (wptr == '0) ? host_inst : prog_buf[0];
                            rptr      <= '0;
                            rd_cnt    <= '0;
                            wd        <= '0;
                            state     <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    wd     <= wd + 1'b1;
                    rd_cnt <= rd_cnt_nxt;
                    if (last_rd) begin
                        imem_in_v <= 1'b0;
                        imem_in   <= '0;
                        state     <= S_DRAIN;
                    end else begin
                        rptr    <= rptr_inc;
                        imem_in <= prog_buf[rptr_inc[AW-1:0]];
                    end
                end
                S_DRAIN: begin
                    wd     <= wd + 1'b1;
                    rd_cnt <= rd_cnt_nxt;
                    if (rd_cnt_nxt == len) begin
                        if (rep != '0) begin
                            rep     <= rep - 1'b1;
                            gap_cnt <= 1'b0;
                            state   <= S_GAP;
                        end else begin
                            done  <= 1'b1;
                            state <= S_DONE;
                        end
                    end else if (wd == wd_last) begin
                        err   <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                end
                S_GAP: begin
                    if (gap_cnt) begin
                        imem_in_v <= 1'b1;
                        imem_in   <= prog_buf[0];
                        rptr      <= '0;
                        rd_cnt    <= '0;
                        wd        <= '0;
                        state     <= S_ISSUE;
                    end else begin
                        gap_cnt <= 1'b1;
                    end
                end
                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    busy      <= 1'b0;
                    host_rdy  <= 1'b0;
                    imem_in_v <= 1'b0;
                    state     <= S_IDLE;
                end
            endcase
        end
    end
endmodule
